instr_fetch: RTL

- Instruction fetch/issue unit; the producer end of the decoder's instruction interface.
- Reads 32-bit words from instruction memory through a req/valid handshake.
- Issues each word to the decoder either as one long instruction or as two short halves, and drives the select between the halves.
- Tracks the word-addressed PC, honours core stalls, and redirects on taken jumps; sits between instruction memory and the decoder in each core.

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
//   Constants shared between the instruction fetch unit and the decoder:
//     - fetch FSM state encodings (REQ, WAIT, ISSUE_HI, ISSUE_LO, FLUSH)
//     - half-select encodings on instr_choose (HALF_UPPER / HALF_LOWER)
//     - the bit position that marks a long-format instruction word
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

    // Fetch FSM state encodings.
    localparam logic [2:0] REQ      = 3'd0;
    localparam logic [2:0] WAIT     = 3'd1;
    localparam logic [2:0] ISSUE_HI = 3'd2;
    localparam logic [2:0] ISSUE_LO = 3'd3;
    localparam logic [2:0] FLUSH    = 3'd4;

    // instr_choose encodings; the decoder uses the same values.
    localparam logic HALF_UPPER = 1'b0;   // long_instr[WIDTH-1:WIDTH/2]
    localparam logic HALF_LOWER = 1'b1;   // long_instr[WIDTH/2-1:0]

    // The top bit of a fetched word selects the long format.
    function automatic int unsigned long_bit_index(input int unsigned width);
        return width - 1;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch/issue unit. Reads one word at a time from instruction
//   memory over a req/valid handshake and hands it to the decoder either as a
//   single long instruction or as two short halves (upper first).
//
// Ports
//   clk          core clock
//   rst          synchronous active-high reset
//   imem_req     one-cycle read request pulse
//   imem_addr    word address of the request (always equals pc)
//   imem_rdata   read data, meaningful only while imem_valid=1
//   imem_valid   read data valid, one per request, latency >= 1 cycle
//   stall        core cannot accept an instruction this cycle
//   redirect     taken jump, one-cycle pulse; beats every other event
//   redirect_pc  jump target word address
//   long_instr   held instruction word for the decoder
//   instr_choose half select (HALF_UPPER / HALF_LOWER)
//   dec_en       registered one-cycle pulse: decoder consumes the issue
//   pc           word address being fetched / issued
// -----------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned           WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0]      imem_rdata,
    input  logic                  imem_valid,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0]      long_instr,
    output logic                  instr_choose,
    output logic                  dec_en,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam int unsigned LONG_BIT = long_bit_index(WIDTH);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]      long_instr_q, long_instr_d;
    logic                  instr_choose_q, instr_choose_d;
    logic                  dec_en_q, dec_en_d;

    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  long_fmt;

    // Natural wrap at all-ones gives the modulo-2^ADDR_WIDTH PC.
    assign pc_inc   = pc_q + ADDR_WIDTH'(1);
    assign long_fmt = long_instr_q[LONG_BIT];

    // dec_en is registered, so instr_choose is loaded with the half being
    // issued on the same edge that raises dec_en. That keeps the select
    // stable for the whole dec_en cycle; it therefore still shows the upper
    // half while waiting in ISSUE_LO and flips to lower only when the lower
    // half is actually issued.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        long_instr_d   = long_instr_q;
        instr_choose_d = instr_choose_q;
        dec_en_d       = 1'b0;

        if (redirect) begin
            pc_d           = redirect_pc;
            instr_choose_d = HALF_UPPER;
            case (state_q)
                // A response still owed must be swallowed before refetching.
                WAIT:    state_d = imem_valid ? REQ : FLUSH;
                // The owed response may land in this very cycle; once it
                // has, nothing is outstanding and the new fetch can start.
                FLUSH:   state_d = imem_valid ? REQ : FLUSH;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    state_d = WAIT;
                end

                WAIT: begin
                    if (imem_valid) begin
                        long_instr_d   = imem_rdata;
                        instr_choose_d = HALF_UPPER;
                        state_d        = ISSUE_HI;
                    end
                end

                ISSUE_HI: begin
                    if (!stall) begin
                        dec_en_d       = 1'b1;
                        instr_choose_d = HALF_UPPER;
                        if (long_fmt) begin
                            pc_d    = pc_inc;
                            state_d = REQ;
                        end else begin
                            state_d = ISSUE_LO;
                        end
                    end
                end

                ISSUE_LO: begin
                    if (!stall) begin
                        dec_en_d       = 1'b1;
                        instr_choose_d = HALF_LOWER;
                        pc_d           = pc_inc;
                        state_d        = REQ;
                    end
                end

                FLUSH: begin
                    if (imem_valid) begin
                        state_d = REQ;
                    end
                end

                default: begin
                    state_d = REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= REQ;
            pc_q           <= RESET_PC;
            long_instr_q   <= '0;
            instr_choose_q <= HALF_UPPER;
            dec_en_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            long_instr_q   <= long_instr_d;
            instr_choose_q <= instr_choose_d;
            dec_en_q       <= dec_en_d;
        end
    end

    // A redirect in REQ cancels the request before it leaves the unit.
    assign imem_req     = (state_q == REQ) && !redirect && !rst;
    assign imem_addr    = pc_q;
    assign pc           = pc_q;
    assign long_instr   = long_instr_q;
    assign instr_choose = instr_choose_q;
    assign dec_en       = dec_en_q;

endmodule
